// File: rtl/seg7_pattern_reader_if.sv
// Bundle between a 7-segment bus sampler and its digit consumer.
// The slave side is the reader: it takes hex_in and out_ready and produces the digit stream.
// The master side is whoever drives the display bus and consumes the digits.
interface seg7_pattern_reader_if;
    logic [6:0] hex_in;
    logic       out_ready;
    logic       out_valid;
    logic [3:0] out_digit;
    logic       out_err;
    logic       overrun;

    modport slave (
        input  hex_in,
        input  out_ready,
        output out_valid,
        output out_digit,
        output out_err,
        output overrun
    );

    modport master (
        output hex_in,
        output out_ready,
        input  out_valid,
        input  out_digit,
        input  out_err,
        input  overrun
    );
endinterface

// File: rtl/seg7_pattern_reader.sv
// Recovers a hex digit from an active-low 7-segment bus {g,f,e,d,c,b,a} after glitch filtering.
// Latency: STABLE_CYCLES+1 edges from the first sample of a new pattern to out_valid.
// Backpressure: one-entry output; a new report arriving while full and not ready is dropped and sets sticky overrun.
module seg7_pattern_reader #(
    parameter int STABLE_CYCLES = 4
) (
    input logic                   clk,
    input logic                   reset,
    seg7_pattern_reader_if.slave  bus
);
    localparam int            CW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_ARM = CW'(STABLE_CYCLES - 1);
    localparam logic [6:0]    BLANK   = 7'b1111111;

    typedef enum logic {EMPTY, FULL} state_t;

    logic [6:0]    hex_q;
    logic [6:0]    prev;
    logic [6:0]    last_acc;
    logic [CW-1:0] cnt;
    logic          accept;

    state_t        state, state_nx;
    logic [3:0]    digit, digit_nx;
    logic          err, err_nx;
    logic          ovr, ovr_nx;

    logic          glyph_ok;
    logic          glyph_blank;
    logic [3:0]    glyph_digit;

    // An accepted pattern is the one that has just completed its stability run and differs from the last accepted one.
    assign accept = (hex_q == prev) && (cnt == CNT_ARM) && (prev != last_acc);

    // Input register and stability tracker; the counter saturates so a held pattern fires only once.
    always_ff @(posedge clk) begin
        if (reset) begin
            hex_q    <= BLANK;
            prev     <= BLANK;
            last_acc <= BLANK;
            cnt      <= '0;
        end else begin
            hex_q <= bus.hex_in;
            if (hex_q != prev) begin
                prev <= hex_q;
                cnt  <= CW'(1);
            end else if (cnt < CNT_MAX) begin
                cnt <= cnt + CW'(1);
            end
            if (accept) begin
                last_acc <= prev;
            end
        end
    end

    // Glyph lookup on the pattern being accepted.
    always_comb begin
        glyph_ok    = 1'b1;
        glyph_blank = 1'b0;
        glyph_digit = 4'h0;
        case (prev)
            7'b1000000: glyph_digit = 4'h0;
            7'b1111001: glyph_digit = 4'h1;
            7'b0100100: glyph_digit = 4'h2;
            7'b0110000: glyph_digit = 4'h3;
            7'b0011001: glyph_digit = 4'h4;
            7'b0010010: glyph_digit = 4'h5;
            7'b0000010: glyph_digit = 4'h6;
            7'b1111000: glyph_digit = 4'h7;
            7'b0000000: glyph_digit = 4'h8;
            7'b0010000: glyph_digit = 4'h9;
            7'b0001000: glyph_digit = 4'hA;
            7'b0000011: glyph_digit = 4'hB;
            7'b1000110: glyph_digit = 4'hC;
            7'b0100001: glyph_digit = 4'hD;
            7'b0000110: glyph_digit = 4'hE;
            7'b0001110: glyph_digit = 4'hF;
            7'b1111111: begin
                glyph_ok    = 1'b0;
                glyph_blank = 1'b1;
            end
            default:    glyph_ok = 1'b0;
        endcase
    end

    // Output state and data registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
            digit <= 4'h0;
            err   <= 1'b0;
            ovr   <= 1'b0;
        end else begin
            state <= state_nx;
            digit <= digit_nx;
            err   <= err_nx;
            ovr   <= ovr_nx;
        end
    end

    // Next-state logic: blank accepts never produce output; a non-blank accept while full needs ready to replace the held data.
    always_comb begin
        state_nx = state;
        digit_nx = digit;
        err_nx   = err;
        ovr_nx   = ovr;
        case (state)
            EMPTY: begin
                if (accept && !glyph_blank) begin
                    digit_nx = glyph_ok ? glyph_digit : 4'h0;
                    err_nx   = !glyph_ok;
                    state_nx = FULL;
                end
            end
            FULL: begin
                if (accept && !glyph_blank) begin
                    if (bus.out_ready) begin
                        digit_nx = glyph_ok ? glyph_digit : 4'h0;
                        err_nx   = !glyph_ok;
                    end else begin
                        ovr_nx = 1'b1;
                    end
                end else if (bus.out_ready) begin
                    state_nx = EMPTY;
                end
            end
            default: state_nx = EMPTY;
        endcase
    end

    assign bus.out_valid = (state == FULL);
    assign bus.out_digit = digit;
    assign bus.out_err   = err;
    assign bus.overrun   = ovr;
endmodule
